tge_mc_packetizer: RTL and testbench
====================================

TGE_MC_PACKETIZER -- requirements
Module: tge_mc_packetizer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels (1..16).
REQ-002 SHALL have parameter DIN_WIDTH, default 128, per-channel input word width, an integer multiple of 64.
REQ-003 SHALL have parameter FIFO_DEPTH, default 512, per-channel buffer depth in 64-bit words, a power of 2.
REQ-004 SHALL have port clk  in  1  sole clock; every register is clocked on its rising edge.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-006 SHALL have port din  in  N_CH*DIN_WIDTH  channel c occupies bits [c*DIN_WIDTH +: DIN_WIDTH].
REQ-007 SHALL have port din_valid  in  N_CH  per-channel write strobe.
REQ-008 SHALL have port enable  in  1  permits new packets to start.
REQ-009 SHALL have port pkt_len  in  32  payload words per packet.
REQ-010 SHALL have port sleep_cycles  in  32  idle cycles inserted after each packet.
REQ-011 SHALL have port config_tx_dest_ip  in  32  destination IP.
REQ-012 SHALL have port config_tx_base_port  in  16  UDP port of channel 0.
REQ-013 SHALL have port tx_data  out  64  word to TGE.
REQ-014 SHALL have port tx_valid  out  1  tx_data qualifier.
REQ-015 SHALL have port tx_eof  out  1  last word of packet; asserted only with tx_valid.
REQ-016 SHALL have port tx_dest_ip  out  32  destination IP.
REQ-017 SHALL have port tx_dest_port  out  16  destination port = config_tx_base_port + channel of current packet.
REQ-018 SHALL have port fifo_full  out  N_CH  per-channel buffer full.
REQ-019 SHALL have port overflow  out  N_CH  sticky per-channel drop flag.

Function
REQ-020 SHALL split each accepted DIN_WIDTH word into DIN_WIDTH/64 words, most-significant 64 bits first, in the channel's buffer.
REQ-021 SHALL drop the whole input word when din_valid[c] is 1 and the buffer lacks room for all its 64-bit words, and SHALL set overflow[c].
REQ-022 SHALL implement states IDLE, HEADER, PAYLOAD, GAP; reset state is IDLE.
REQ-023 IDLE: when enable=1, SHALL select the first channel at or after rr_ptr (modulo N_CH) whose buffer level >= pkt_len, latch channel and pkt_len, and go to HEADER; otherwise stay in IDLE.
REQ-024 SHALL advance rr_ptr to selected channel + 1 (mod N_CH) on each selection.
REQ-025 HEADER: SHALL emit one word, [63:56]=channel, [55:32]=0, [31:0]=that channel's sequence number.
REQ-026 PAYLOAD: SHALL emit exactly the latched pkt_len words, one per cycle without gaps, with tx_eof on the last.
REQ-027 A latched pkt_len of 0 SHALL yield a header-only packet, with tx_eof on the header.
REQ-028 A channel's sequence number SHALL increment by 1 after each of its packets and wrap from 2^32-1 to 0.
REQ-029 GAP: SHALL hold tx_valid=0 for sleep_cycles cycles, then return to IDLE; sleep_cycles=0 SHALL give a direct return to IDLE.
REQ-030 All tx_* outputs SHALL be registered; the first word appears 2 cycles after the IDLE selection cycle.
REQ-031 pkt_len, tx_dest_port and the channel SHALL stay constant while a packet is in flight.
REQ-032 Deasserting enable mid-packet SHALL NOT truncate the packet.
REQ-033 A pkt_len greater than FIFO_DEPTH SHALL produce no packets and no deadlock.
REQ-034 A simultaneous write and read on one buffer SHALL both take effect, and the level SHALL stay exact.

Reset
REQ-035 When rst_n=0, SHALL clear tx_valid, tx_eof, tx_data, overflow, all buffers, sequence numbers and rr_ptr, and set the state to IDLE; tx_dest_ip SHALL follow config_tx_dest_ip.
REQ-036 Reset during a packet SHALL abort it on the next edge, with no tx_eof emitted.

Structure
REQ-037 SHALL place state encoding, header field offsets and the 64-bit word constant in shared package tge_pkg.
REQ-038 SHALL instantiate one sub-module per channel, chan_piso_fifo, which provides width conversion, a buffer, a level output and full.

Verification
REQ-039 N_CH=4, pkt_len=8, sleep=0, 16 words on ch2 only -> two packets on port base+2 with seq 0 and 1, 9 words each, tx_eof on the 9th.
REQ-040 All channels pre-filled with 8 words, pkt_len=8 -> packets sent in channel order 0,1,2,3, then idle.
REQ-041 sleep_cycles=5 -> exactly 5 tx_valid=0 cycles between eof and the next header.
REQ-042 Write 600 words to ch1 with enable=0 -> fifo_full[1]=1, overflow[1]=1, and the first 512 words later transmitted intact.
REQ-043 pkt_len=0 -> single-word packets carrying tx_eof and incrementing seq.
REQ-044 rst_n=0 at the 3rd payload word -> tx_valid=0 next cycle, seq and overflow return to 0.

Source files
------------

// File: rtl/tge_pkg.sv
// Shared definitions for the multi-channel 10GbE packetizer: FSM encoding,
// header field layout and the transmit word width.
package tge_pkg;

   localparam int WORD_W      = 64;
   localparam int HDR_CH_LSB  = 56;
   localparam int HDR_CH_W    = 8;
   localparam int HDR_SEQ_LSB = 0;
   localparam int HDR_SEQ_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

   // Header word: channel in the top byte, sequence number in the low 32 bits.
   function automatic logic [WORD_W-1:0] make_header(input logic [HDR_CH_W-1:0]  ch,
                                                     input logic [HDR_SEQ_W-1:0] seq);
      logic [WORD_W-1:0] w;
      w = '0;
      w[HDR_CH_LSB  +: HDR_CH_W]  = ch;
      w[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
      return w;
   endfunction

endpackage

// File: rtl/chan_piso_fifo.sv
// Per-channel buffer: accepts one DIN_WIDTH word per cycle, stores it as
// DIN_WIDTH/64 words (most-significant first) and hands them out one per read.
// A word that does not fit entirely is dropped and flagged in a sticky bit.
module chan_piso_fifo
   import tge_pkg::*;
#(
   parameter int DIN_WIDTH  = 128,
   parameter int FIFO_DEPTH = 512,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIN_WIDTH-1:0] din,
   input  logic                 din_valid,
   input  logic                 rd_en,
   output logic [WORD_W-1:0]    rd_data,
   output logic [LVL_W-1:0]     level,
   output logic                 full,
   output logic                 overflow
);

   localparam int K  = DIN_WIDTH / WORD_W;
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic              r_overflow;

   logic              w_rd;
   logic              w_wr;
   logic              w_room;
   logic [31:0]       w_need;

   // A read in the same cycle frees a slot, so it counts towards the room check.
   assign w_rd   = rd_en && (r_level != '0);
   assign w_need = 32'(r_level) - 32'(w_rd) + 32'(K);
   assign w_room = (w_need <= 32'(FIFO_DEPTH));
   assign w_wr   = din_valid && w_room;

   // Storage: split the accepted input word, most-significant slice first.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int k = 0; k < K; k++) begin
            r_mem[r_wr_ptr + AW'(k)] <= din[DIN_WIDTH-1-WORD_W*k -: WORD_W];
         end
      end
   end

   // Pointers, exact level under simultaneous write/read, sticky drop flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(K);
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= r_level + (w_wr ? LVL_W'(K) : '0) - (w_rd ? LVL_W'(1) : '0);
         if (din_valid && !w_room) r_overflow <= 1'b1;
      end
   end

   assign rd_data  = r_mem[r_rd_ptr];
   assign level    = r_level;
   assign full     = (r_level == LVL_W'(FIFO_DEPTH));
   assign overflow = r_overflow;

endmodule

// File: rtl/tge_mc_packetizer.sv
// Multi-channel packetizer: buffers per-channel data and emits round-robin
// packets (one header word + pkt_len payload words) toward the TGE core.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | look for the next channel with >= pkt_len words buffered
// ST_HEADER  | emit header word (channel, sequence number)
// ST_PAYLOAD | stream pkt_len words from the selected channel
// ST_GAP     | inter-packet idle; the IDLE cycle completes the gap count
module tge_mc_packetizer
   import tge_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int DIN_WIDTH  = 128,
   parameter int FIFO_DEPTH = 512
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_CH*DIN_WIDTH-1:0] din,
   input  logic [N_CH-1:0]           din_valid,
   input  logic                      enable,
   input  logic [31:0]               pkt_len,
   input  logic [31:0]               sleep_cycles,
   input  logic [31:0]               config_tx_dest_ip,
   input  logic [15:0]               config_tx_base_port,
   output logic [WORD_W-1:0]         tx_data,
   output logic                      tx_valid,
   output logic                      tx_eof,
   output logic [31:0]               tx_dest_ip,
   output logic [15:0]               tx_dest_port,
   output logic [N_CH-1:0]           fifo_full,
   output logic [N_CH-1:0]           overflow
);

   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   state_t            r_state;
   logic [CH_W-1:0]   r_ch;
   logic [CH_W-1:0]   r_rr_ptr;
   logic [31:0]       r_len;
   logic [31:0]       r_cnt;
   logic [31:0]       r_gap;
   logic [31:0]       r_seq [N_CH];
   logic [WORD_W-1:0] r_tx_data;
   logic              r_tx_valid;
   logic              r_tx_eof;
   logic [15:0]       r_dest_port;
   logic [31:0]       r_dest_ip;

   logic [N_CH-1:0]   w_rd_en;
   logic [N_CH-1:0]   w_ready;
   logic [WORD_W-1:0] w_rd_data [N_CH];
   logic [LVL_W-1:0]  w_level [N_CH];
   logic              w_any;
   logic              w_hi;
   logic [CH_W-1:0]   w_any_sel;
   logic [CH_W-1:0]   w_hi_sel;
   logic [CH_W-1:0]   w_sel;
   logic [CH_W-1:0]   w_rr_next;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign w_rd_en[c] = (r_state == ST_PAYLOAD) && (r_ch == CH_W'(c));
      assign w_ready[c] = (32'(w_level[c]) >= pkt_len);

      chan_piso_fifo #(
         .DIN_WIDTH  (DIN_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH),
         .LVL_W      (LVL_W)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .din       (din[c*DIN_WIDTH +: DIN_WIDTH]),
         .din_valid (din_valid[c]),
         .rd_en     (w_rd_en[c]),
         .rd_data   (w_rd_data[c]),
         .level     (w_level[c]),
         .full      (fifo_full[c]),
         .overflow  (overflow[c])
      );
   end

   // Round-robin pick: lowest ready channel at/after rr_ptr, else lowest ready overall.
   always_comb begin
      w_any     = 1'b0;
      w_hi      = 1'b0;
      w_any_sel = '0;
      w_hi_sel  = '0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         if (w_ready[c]) begin
            w_any     = 1'b1;
            w_any_sel = CH_W'(c);
            if (CH_W'(c) >= r_rr_ptr) begin
               w_hi     = 1'b1;
               w_hi_sel = CH_W'(c);
            end
         end
      end
      w_sel = w_hi ? w_hi_sel : w_any_sel;
   end

   assign w_rr_next = (w_sel == CH_W'(N_CH - 1)) ? '0 : w_sel + 1'b1;

   // Packet sequencer with registered transmit outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_ch        <= '0;
         r_rr_ptr    <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_gap       <= '0;
         r_tx_data   <= '0;
         r_tx_valid  <= 1'b0;
         r_tx_eof    <= 1'b0;
         r_dest_port <= '0;
         for (int c = 0; c < N_CH; c++) r_seq[c] <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tx_valid <= 1'b0;
               r_tx_eof   <= 1'b0;
               if (enable && w_any) begin
                  r_ch        <= w_sel;
                  r_len       <= pkt_len;
                  r_rr_ptr    <= w_rr_next;
                  r_dest_port <= config_tx_base_port + 16'(w_sel);
                  r_state     <= ST_HEADER;
               end
            end
            ST_HEADER: begin
               r_tx_valid <= 1'b1;
               r_tx_data  <= make_header(8'(r_ch), r_seq[r_ch]);
               r_cnt      <= r_len;
               if (r_len == '0) begin
                  r_tx_eof     <= 1'b1;
                  r_seq[r_ch]  <= r_seq[r_ch] + 1'b1;
                  r_gap        <= sleep_cycles - 1'b1;
                  r_state      <= (sleep_cycles > 32'd1) ? ST_GAP : ST_IDLE;
               end else begin
                  r_tx_eof <= 1'b0;
                  r_state  <= ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               r_tx_valid <= 1'b1;
               r_tx_data  <= w_rd_data[r_ch];
               r_cnt      <= r_cnt - 1'b1;
               if (r_cnt == 32'd1) begin
                  r_tx_eof    <= 1'b1;
                  r_seq[r_ch] <= r_seq[r_ch] + 1'b1;
                  r_gap       <= sleep_cycles - 1'b1;
                  r_state     <= (sleep_cycles > 32'd1) ? ST_GAP : ST_IDLE;
               end else begin
                  r_tx_eof <= 1'b0;
               end
            end
            ST_GAP: begin
               r_tx_valid <= 1'b0;
               r_tx_eof   <= 1'b0;
               if (r_gap == 32'd1) r_state <= ST_IDLE;
               else                r_gap   <= r_gap - 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Destination IP is a straight registered copy of the configuration.
   always_ff @(posedge clk) begin
      r_dest_ip <= config_tx_dest_ip;
   end

   assign tx_data      = r_tx_data;
   assign tx_valid     = r_tx_valid;
   assign tx_eof       = r_tx_eof;
   assign tx_dest_ip   = r_dest_ip;
   assign tx_dest_port = r_dest_port;

endmodule

// File: tb/tb_tge_mc_packetizer.sv
// Scoreboard bench for tge_mc_packetizer: stimulus pushes expected words,
// a negedge monitor pops and compares every valid transmit word.
module tb_tge_mc_packetizer;

   localparam int N_CH  = 4;
   localparam int DW    = 128;
   localparam int DEPTH = 512;
   localparam logic [15:0] BASE = 16'd5000;
   localparam logic [31:0] IP   = 32'hC0A8_0A01;

   logic                 clk;
   logic                 rst_n;
   logic [N_CH*DW-1:0]   din;
   logic [N_CH-1:0]      din_valid;
   logic                 enable;
   logic [31:0]          pkt_len;
   logic [31:0]          sleep_cycles;
   logic [31:0]          cfg_ip;
   logic [15:0]          cfg_port;
   logic [63:0]          tx_data;
   logic                 tx_valid;
   logic                 tx_eof;
   logic [31:0]          tx_dest_ip;
   logic [15:0]          tx_dest_port;
   logic [N_CH-1:0]      fifo_full;
   logic [N_CH-1:0]      overflow;

   tge_mc_packetizer #(.N_CH(N_CH), .DIN_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .din                 (din),
      .din_valid           (din_valid),
      .enable              (enable),
      .pkt_len             (pkt_len),
      .sleep_cycles        (sleep_cycles),
      .config_tx_dest_ip   (cfg_ip),
      .config_tx_base_port (cfg_port),
      .tx_data             (tx_data),
      .tx_valid            (tx_valid),
      .tx_eof              (tx_eof),
      .tx_dest_ip          (tx_dest_ip),
      .tx_dest_port        (tx_dest_port),
      .fifo_full           (fifo_full),
      .overflow            (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic        eof;
      logic [15:0] port;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad   = 0;
   logic [31:0] seq_m [N_CH];
   int          wr_idx [N_CH];
   int          rd_idx [N_CH];
   bit          in_gap = 1'b0;
   int          gap_cnt = 0;
   int          last_gap = -1;

   function automatic logic [63:0] w64(input int c, input int i);
      logic [31:0] cc;
      logic [31:0] ii;
      cc = c;
      ii = i;
      return {cc[7:0], 24'h5A5A5A, ii};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Expected packet; only the first 'emit' words (header included) are queued.
   task automatic push_pkt(input int c, input int len, input int emit);
      exp_t        e;
      logic [31:0] cc;
      cc     = c;
      e.data = {cc[7:0], 24'h0, seq_m[c]};
      e.eof  = (len == 0);
      e.port = BASE + cc[15:0];
      if (emit > 0) sb.push_back(e);
      for (int k = 0; k < len; k++) begin
         e.data = w64(c, rd_idx[c]);
         e.eof  = (k == len - 1);
         rd_idx[c]++;
         if (k + 1 < emit) sb.push_back(e);
      end
      seq_m[c]++;
   endtask

   task automatic drive_ch(input int c, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         din = '0;
         din[c*DW +: DW] = {w64(c, 2*wr_idx[c]), w64(c, 2*wr_idx[c] + 1)};
         din_valid = '0;
         din_valid[c] = 1'b1;
         wr_idx[c]++;
      end
      @(posedge clk); #1;
      din_valid = '0;
      din = '0;
   endtask

   task automatic clear_model();
      for (int c = 0; c < N_CH; c++) begin
         seq_m[c]  = '0;
         wr_idx[c] = 0;
         rd_idx[c] = 0;
      end
      sb.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      enable = 1'b0;
      din_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic wait_drain(input string name, input int max_cyc);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cyc) begin
         @(negedge clk); #1;
         n++;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d words still pending after %0d cycles, want 0", name, sb.size(), n);
         sb.delete();
      end
   endtask

   // Monitor: every valid word must match the head of the scoreboard.
   always @(negedge clk) begin
      if (tx_valid === 1'b1) begin
         if (in_gap) begin
            last_gap = gap_cnt;
            in_gap   = 1'b0;
         end
         if (tx_eof === 1'b1) begin
            in_gap  = 1'b1;
            gap_cnt = 0;
         end
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_word: got data=%h eof=%b port=%0d, want no word", tx_data, tx_eof, tx_dest_port);
         end else begin
            mon_e = sb.pop_front();
            if ({tx_data, tx_eof, tx_dest_port} !== {mon_e.data, mon_e.eof, mon_e.port} || tx_dest_ip !== IP) begin
               bad++;
               $display("FAIL tx_word: got data=%h eof=%b port=%0d ip=%h want data=%h eof=%b port=%0d ip=%h",
                        tx_data, tx_eof, tx_dest_port, tx_dest_ip, mon_e.data, mon_e.eof, mon_e.port, IP);
            end
         end
      end else begin
         if (in_gap) gap_cnt++;
         total++;
         if (tx_eof !== 1'b0) begin
            bad++;
            $display("FAIL eof_without_valid: got eof=%b valid=%b want eof=0", tx_eof, tx_valid);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int consumed;
      rst_n        = 1'b0;
      enable       = 1'b0;
      din          = '0;
      din_valid    = '0;
      pkt_len      = 32'd8;
      sleep_cycles = 32'd0;
      cfg_ip       = IP;
      cfg_port     = BASE;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid",   64'(tx_valid),   64'd0);
      check("rst_tx_eof",     64'(tx_eof),     64'd0);
      check("rst_tx_data",    tx_data,         64'd0);
      check("rst_overflow",   64'(overflow),   64'd0);
      check("rst_fifo_full",  64'(fifo_full),  64'd0);
      check("rst_tx_dest_ip", 64'(tx_dest_ip), 64'(IP));
      rst_n = 1'b1;

      // Two packets on channel 2; enable dropped after the first header.
      drive_ch(2, 8);
      push_pkt(2, 8, 9);
      enable = 1'b1;
      n = 0;
      while (tx_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      enable = 1'b0;
      check("s1_first_header_seen", 64'(tx_valid), 64'd1);
      wait_drain("s1_pkt0", 50);
      repeat (20) @(posedge clk);
      #1;
      push_pkt(2, 8, 9);
      enable = 1'b1;
      wait_drain("s1_pkt1", 60);
      enable = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // All channels ready: service order 0,1,2,3 then idle.
      do_reset();
      for (int c = 0; c < N_CH; c++) drive_ch(c, 4);
      for (int c = 0; c < N_CH; c++) push_pkt(c, 8, 9);
      enable = 1'b1;
      wait_drain("s2_order", 200);
      repeat (30) @(posedge clk);
      #1;
      enable = 1'b0;

      // Inter-packet gap with sleep_cycles = 5.
      sleep_cycles = 32'd5;
      drive_ch(0, 8);
      push_pkt(0, 8, 9);
      push_pkt(0, 8, 9);
      in_gap   = 1'b0;
      last_gap = -1;
      enable   = 1'b1;
      wait_drain("s3_two_pkts", 100);
      enable = 1'b0;
      check("s3_gap_cycles", 64'(last_gap), 64'd5);
      sleep_cycles = 32'd0;
      repeat (10) @(posedge clk);
      #1;

      // Header-only packets, round robin over all channels.
      do_reset();
      pkt_len = 32'd0;
      for (int i = 0; i < 40; i++) push_pkt(i % N_CH, 0, 1);
      enable = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      consumed = 40 - sb.size();
      check("s4_hdr_only_count_ge8", 64'(consumed >= 8), 64'd1);
      sb.delete();

      // Overflow on channel 1, oversize pkt_len, then one 512-word packet.
      do_reset();
      pkt_len = 32'd8;
      drive_ch(1, 300);
      check("s5_fifo_full1",   64'(fifo_full[1]), 64'd1);
      check("s5_fifo_full0",   64'(fifo_full[0]), 64'd0);
      check("s5_overflow_vec", 64'(overflow),     64'h2);
      pkt_len = 32'd513;
      enable  = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      enable  = 1'b0;
      check("s5_no_pkt_oversize", 64'(tx_valid), 64'd0);
      pkt_len = 32'd512;
      push_pkt(1, 512, 513);
      enable = 1'b1;
      wait_drain("s5_full_pkt", 700);
      enable = 1'b0;
      check("s5_not_full_after", 64'(fifo_full[1]), 64'd0);
      check("s5_overflow_sticky", 64'(overflow[1]), 64'd1);

      // Concurrent write and read on channel 3.
      do_reset();
      pkt_len = 32'd8;
      for (int p = 0; p < 4; p++) push_pkt(3, 8, 9);
      enable = 1'b1;
      drive_ch(3, 16);
      wait_drain("s6_concurrent", 200);
      enable = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // Reset at the third payload word, then sequence restarts at 0.
      do_reset();
      pkt_len = 32'd8;
      drive_ch(2, 260);
      drive_ch(0, 4);
      check("s7_overflow2_set", 64'(overflow[2]), 64'd1);
      push_pkt(0, 8, 4);
      enable = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk); #1;
         n++;
      end
      rst_n = 1'b0;
      check("s7_reached_third_payload", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
      check("s7_valid_after_rst",    64'(tx_valid),  64'd0);
      check("s7_eof_after_rst",      64'(tx_eof),    64'd0);
      check("s7_overflow_after_rst", 64'(overflow),  64'd0);
      check("s7_full_after_rst",     64'(fifo_full), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_model();
      push_pkt(0, 8, 9);
      drive_ch(0, 4);
      wait_drain("s7_seq_restart", 60);
      enable = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
